// File: rtl/vga_timing.sv
// Raster timing generator: pixel-rate x/y counters, visible/sync decode, and a ce-qualified
// delay line that lines de/hsync/vsync up with the palette's registered colour output.
module vga_timing #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   ce,
    output logic [$clog2(H_VISIBLE+H_FRONT+H_SYNC+H_BACK)-1:0]     x,
    output logic [$clog2(V_VISIBLE+V_FRONT+V_SYNC+V_BACK)-1:0]     y,
    output logic                                                   active,
    output logic                                                   frame_start,
    output logic                                                   de,
    output logic                                                   hsync,
    output logic                                                   vsync
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    if (PIPE_DELAY < 1 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
        $error("vga_timing: PIPE_DELAY must be >= 1 and all porch/sync widths nonzero");
    end

    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic          x_last, y_last;

    assign x_last = (x_q == HW'(H_TOTAL - 1));
    assign y_last = (y_q == VW'(V_TOTAL - 1));

    // Line and frame wrap resolve in the same edge at the last pixel of the frame.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (ce) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    logic hs_on, vs_on;
    logic hs_lvl, vs_lvl;

    assign active = (x_q < HW'(H_VISIBLE)) && (y_q < VW'(V_VISIBLE));
    assign hs_on  = (x_q >= HW'(HS_START)) && (x_q < HW'(HS_END));
    assign vs_on  = (y_q >= VW'(VS_START)) && (y_q < VW'(VS_END));
    assign hs_lvl = hs_on ? HSYNC_POL : ~HSYNC_POL;
    assign vs_lvl = vs_on ? VSYNC_POL : ~VSYNC_POL;

    assign frame_start = ce && (x_q == '0) && (y_q == '0);
    assign x           = x_q;
    assign y           = y_q;

    // Each stage holds {de, hsync, vsync} at pin level, so reset is the idle level.
    localparam logic [2:0] STAGE_RST = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

    for (genvar i = 0; i < PIPE_DELAY; i++) begin : g_pipe
        logic [2:0] stage_d;
        logic [2:0] stage_q;

        if (i == 0) begin : g_first
            assign stage_d = {active, hs_lvl, vs_lvl};
        end else begin : g_next
            assign stage_d = g_pipe[i-1].stage_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= STAGE_RST;
            end else if (ce) begin
                stage_q <= stage_d;
            end
        end
    end

    assign {de, hsync, vsync} = g_pipe[PIPE_DELAY-1].stage_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: small raster checked every clock against a pixel-index model,
// plus a default 640x480 instance checked over its first two lines.
module tb_vga_timing;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int PD = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic [2:0] x, y;
    logic       active, frame_start, de, hsync, vsync;
    logic [9:0] bx, by;
    logic       bactive, bframe, bde, bhs, bvs;

    int n_pass = 0;
    int n_total = 0;
    int n = 0;            // ce-qualified pixel steps since reset release
    bit big_on = 1'b0;
    int big_act = 0, big_de = 0, big_hs_low = 0, big_vs_low = 0, big_fs = 0;

    always #5 clk = ~clk;

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(PD)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(x), .y(y), .active(active),
        .frame_start(frame_start), .de(de), .hsync(hsync), .vsync(vsync)
    );

    vga_timing u_dut_vga (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(bx), .y(by), .active(bactive),
        .frame_start(bframe), .de(bde), .hsync(bhs), .vsync(bvs)
    );

    always @(negedge clk) begin
        if (big_on) begin
            if (bactive) big_act++;
            if (bde) big_de++;
            if (!bhs) big_hs_low++;
            if (!bvs) big_vs_low++;
            if (bframe) big_fs++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t, n=%0d)", tag, obs, exp, $time, n);
    endtask

    function automatic bit m_active(int p);
        return ((p % HT) < HV) && (((p / HT) % VT) < VV);
    endfunction

    function automatic bit m_hs_on(int p);
        int h = p % HT;
        return (h >= HV + HF) && (h < HV + HF + HS);
    endfunction

    function automatic bit m_vs_on(int p);
        int v = (p / HT) % VT;
        return (v >= VV + VF) && (v < VV + VF + VS);
    endfunction

    task automatic check_all(input bit ce_v);
        check("x", 32'(x), 32'(n % HT));
        check("y", 32'(y), 32'((n / HT) % VT));
        check("active", 32'(active), 32'(m_active(n)));
        check("frame_start", 32'(frame_start), 32'(ce_v && (n % FT == 0)));
        if (n >= PD) begin
            check("de", 32'(de), 32'(m_active(n - PD)));
            check("hsync", 32'(hsync), 32'(!m_hs_on(n - PD)));
            check("vsync", 32'(vsync), 32'(!m_vs_on(n - PD)));
        end else begin
            check("de", 32'(de), 32'(0));
            check("hsync", 32'(hsync), 32'(1));
            check("vsync", 32'(vsync), 32'(1));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"}, 32'(x), 32'(0));
        check({tag, "_y"}, 32'(y), 32'(0));
        check({tag, "_de"}, 32'(de), 32'(0));
        check({tag, "_hsync"}, 32'(hsync), 32'(1));
        check({tag, "_vsync"}, 32'(vsync), 32'(1));
    endtask

    // Called #1 after a posedge; leaves time #1 after the next posedge.
    task automatic step(input bit ce_v);
        ce = ce_v;
        @(negedge clk);
        check_all(ce_v);
        @(posedge clk);
        if (ce_v) n++;
        #1;
    endtask

    task automatic mid_reset(input int target);
        int guard = 0;
        while ((n % FT) != target && guard < 2 * FT) begin
            step(1'b1);
            guard++;
        end
        check("reach_target", 32'(n % FT), 32'(target));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        n = 0;
        repeat (20) step(1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        ce = 1'b1;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;

        repeat (2 * FT + 10) step(1'b1);

        for (int i = 0; i < 2 * 4 * FT; i++) step(i % 4 == 0);

        repeat (400) step(1'($urandom_range(0, 1)));

        mid_reset(26);
        mid_reset(10);
        mid_reset(38);

        repeat (200) step(($urandom_range(0, 3) != 0));

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        big_on = 1'b1;
        repeat (1601) step(1'b1);
        big_on = 1'b0;
        check("vga_x_end", 32'(bx), 32'(1));
        check("vga_y_end", 32'(by), 32'(2));
        check("vga_active_cnt", 32'(big_act), 32'(1281));
        check("vga_de_cnt", 32'(big_de), 32'(1280));
        check("vga_hsync_low", 32'(big_hs_low), 32'(192));
        check("vga_vsync_low", 32'(big_vs_low), 32'(0));
        check("vga_frame_start", 32'(big_fs), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator directly upstream of the VGA colour palette stage.
- Runs a horizontal and a vertical counter at pixel rate.
- Drives x/y coordinates and a visible flag to the pixel source (framebuffer/renderer), which feeds pixel indices into the palette.
- Delays the display enable and the h/v syncs by a configurable pipeline depth, so they line up with the palette's one-clock-late colour output at the DAC/pins.

Parameters:
- H_VISIBLE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BACK, 48: horizontal back porch, pixels
- V_VISIBLE, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BACK, 33: vertical back porch, lines
- HSYNC_POL, 0: active level of hsync (0 = active low)
- VSYNC_POL, 0: active level of vsync
- PIPE_DELAY, 1: clocks of delay on de/hsync/vsync; must be at least 1

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock enable; counters and delay line advance only when high
- x  out  HW  horizontal counter, HW = $clog2(H_TOTAL)
- y  out  VW  vertical counter, VW = $clog2(V_TOTAL)
- active  out  1  undelayed visible flag: x < H_VISIBLE && y < V_VISIBLE
- frame_start  out  1  one-cycle pulse: ce && x==0 && y==0
- de  out  1  active delayed by PIPE_DELAY ce-qualified cycles; drives the palette enable
- hsync  out  1  delayed horizontal sync at the HSYNC_POL level
- vsync  out  1  delayed vertical sync at the VSYNC_POL level

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters; V_TOTAL = sum of the four V_* parameters.
- Counters (x, y) are registers.
- On ce: x increments.
  - When x == H_TOTAL-1, x wraps to 0 and y increments.
  - When additionally y == V_TOTAL-1, y wraps to 0.
- Without ce: x and y hold.
- Undelayed syncs:
  - hs_raw is active while H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC.
  - vs_raw is active while V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC.
  - vs_raw changes on the same edge as y, i.e. at the line boundary, not mid-line.
- active, hs_raw and vs_raw are combinational decodes of the counters.
- Delay line: PIPE_DELAY stages of {active, hs_raw, vs_raw}.
  - Shifts only on ce; holds otherwise.
  - de/hsync/vsync are the last stage.
- With PIPE_DELAY=1, the colour the palette emits for coordinate (x,y) appears on the same edge as the de for that coordinate.
- Reset (asynchronous assert, removal synchronised by design of the caller):
  - x=0, y=0.
  - All delay stages: de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- Reset mid-frame: counters and delay line clear immediately; the first post-reset pixel is (0,0) with frame_start asserted on the first ce.
- ce held low indefinitely: all outputs static except frame_start, which is 0.
- Simultaneous line and frame wrap on the same edge is the normal case at (H_TOTAL-1, V_TOTAL-1) and must go to (0,0) in one clock.
- No overflow states: x never reaches H_TOTAL, y never reaches V_TOTAL.
- Elaboration error if PIPE_DELAY < 1 or any porch/sync parameter is 0.
- Expected size: counters, decode and generate-loop delay line, 120-200 lines.

Test Plan:
Small configuration for all tests unless noted: H = 4/1/2/1 (H_TOTAL 8), V = 3/1/1/1 (V_TOTAL 6), PIPE_DELAY=1, active-low syncs, ce tied high.
- Reset release: x=0, y=0, de=0, hsync=1, vsync=1 during reset.
  - First clock after release: frame_start=1, active=1; de rises one clock later.
- Line timing: across one line, active high for x=0..3.
  - hs_raw low for x=5..6, so hsync is low on the clocks after x=5 and x=6.
  - x wraps 7→0 and y increments 0→1 on the same edge.
- Frame timing: vsync low for exactly one full line (8 clocks) starting one clock after y becomes 4.
  - Transition (7,5)→(0,0) happens in one edge; frame_start repeats every 48 clocks.
- ce gating: drive ce with a 1-of-4 pattern.
  - Counters and de/hsync/vsync change only on ce edges; a full frame takes 192 clocks.
  - frame_start is high only on the single ce cycle at (0,0).
- Mid-frame reset: assert rst_n low at (2,3) for 3 clocks.
  - Outputs go to reset values immediately (asynchronously, without waiting for a clock edge).
  - After release, counting restarts at (0,0).
- Default 640x480 configuration: run 2 frames.
  - 800 clocks per line, 525 lines per frame.
  - 307200 de-high clocks per frame.
  - hsync low 96 clocks per line; vsync low 1600 clocks per frame.
